monocycle_boot_ctrl: RTL and testbench

//  Synthesizable boot/run sequencer for one or more monocycle RISC-V harts.
//  - Drives each hart's reset, initial_address and tr (run/trace enable).
//  - Adds a parametrised reset-hold time, per-hart enable mask, single-step mode, halt, and a cycle-limit stop.
//  - Sits between the SoC/debug control and the monocycle core instances.

---
 rtl/monocycle_boot_pkg.sv | 18 +
 rtl/monocycle_boot_ctrl_cycle_counter.sv | 32 +++
 rtl/monocycle_boot_ctrl.sv | 122 ++++++++++++
 tb/tb_monocycle_boot_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/monocycle_boot_pkg.sv
// Shared types and helpers for the monocycle hart boot/run sequencer.
package monocycle_boot_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } boot_state_e;

    // Width of the reset-hold down-counter; never narrower than one bit.
    function automatic int hold_cnt_width(input int reset_hold);
        int w;
        w = $clog2(reset_hold + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/monocycle_boot_ctrl_cycle_counter.sv
// Saturating run-cycle counter with synchronous clear and a terminal-count hit flag.
module boot_cycle_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] limit,
    output logic [CNT_W-1:0] count,
    output logic             limit_hit
);

    logic [CNT_W-1:0] count_next;

    always_comb begin
        count_next = (&count) ? count : count + CNT_W'(1);
        // Hit means the cycle being granted right now is the last one allowed.
        limit_hit  = enable && (limit != '0) && (count_next == limit);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/monocycle_boot_ctrl.sv
// Boot/run sequencer for monocycle RISC-V harts: reset hold, per-hart mask,
// single-step, halt and cycle-limit stop.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | after reset; all harts in reset, waiting for a valid start
// HOLD  | harts held in reset for RESET_HOLD cycles after start
// RUN   | masked harts out of reset; core_tr granted free-run or per step
// DONE  | stopped by halt or cycle limit; harts frozen, count frozen
module monocycle_boot_ctrl
    import monocycle_boot_pkg::*;
#(
    parameter int NUM_HARTS  = 1,
    parameter int ADDR_W     = 32,
    parameter int CNT_W      = 32,
    parameter int RESET_HOLD = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    boot_addr,
    input  logic [NUM_HARTS-1:0] hart_mask,
    input  logic                 step_mode,
    input  logic                 step,
    input  logic                 halt,
    input  logic [CNT_W-1:0]     cycle_limit,
    output logic [NUM_HARTS-1:0] core_reset,
    output logic [ADDR_W-1:0]    core_initial_address,
    output logic [NUM_HARTS-1:0] core_tr,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     cycle_count
);

    localparam int HOLD_W = hold_cnt_width(RESET_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(RESET_HOLD - 1);

    boot_state_e          state;
    logic [HOLD_W-1:0]    hold_cnt;
    logic [NUM_HARTS-1:0] mask_q;
    logic                 mode_q;

    logic start_ok;
    logic cnt_enable;
    logic limit_hit;

    // A start is honoured only when idle or finished, and only with a non-empty mask.
    assign start_ok   = start && (hart_mask != '0) &&
                        ((state == ST_IDLE) || (state == ST_DONE));
    assign cnt_enable = (core_tr != '0);

    boot_cycle_counter #(
        .CNT_W (CNT_W)
    ) u_cycle_counter (
        .clk       (clk),
        .reset     (reset),
        .clear     (start_ok),
        .enable    (cnt_enable),
        .limit     (cycle_limit),
        .count     (cycle_count),
        .limit_hit (limit_hit)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state                <= ST_IDLE;
            hold_cnt             <= '0;
            mask_q               <= '0;
            mode_q               <= 1'b0;
            core_reset           <= '1;
            core_initial_address <= '0;
            core_tr              <= '0;
            busy                 <= 1'b0;
            done                 <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start_ok) begin
                        state                <= ST_HOLD;
                        hold_cnt             <= HOLD_LOAD;
                        mask_q               <= hart_mask;
                        mode_q               <= step_mode;
                        core_initial_address <= boot_addr;
                        core_reset           <= '1;
                        core_tr              <= '0;
                        busy                 <= 1'b1;
                        done                 <= 1'b0;
                    end
                end

                ST_HOLD: begin
                    if (hold_cnt == '0) begin
                        state      <= ST_RUN;
                        core_reset <= ~mask_q;
                        // Free-run grants from the same edge reset falls; step mode waits for step.
                        core_tr    <= mode_q ? '0 : mask_q;
                    end else begin
                        hold_cnt <= hold_cnt - HOLD_W'(1);
                    end
                end

                ST_RUN: begin
                    if (halt || limit_hit) begin
                        state   <= ST_DONE;
                        core_tr <= '0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else if (!mode_q || step) begin
                        core_tr <= mask_q;
                    end else begin
                        core_tr <= '0;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_monocycle_boot_ctrl.sv
// Directed bench for monocycle_boot_ctrl with two harts and a two-cycle reset hold.
module tb_monocycle_boot_ctrl;

    localparam int NUM_HARTS  = 2;
    localparam int ADDR_W     = 32;
    localparam int CNT_W      = 32;
    localparam int RESET_HOLD = 2;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 start;
    logic [ADDR_W-1:0]    boot_addr;
    logic [NUM_HARTS-1:0] hart_mask;
    logic                 step_mode;
    logic                 step;
    logic                 halt;
    logic [CNT_W-1:0]     cycle_limit;
    logic [NUM_HARTS-1:0] core_reset;
    logic [ADDR_W-1:0]    core_initial_address;
    logic [NUM_HARTS-1:0] core_tr;
    logic                 busy;
    logic                 done;
    logic [CNT_W-1:0]     cycle_count;

    int checks   = 0;
    int failures = 0;

    monocycle_boot_ctrl #(
        .NUM_HARTS  (NUM_HARTS),
        .ADDR_W     (ADDR_W),
        .CNT_W      (CNT_W),
        .RESET_HOLD (RESET_HOLD)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .start                (start),
        .boot_addr            (boot_addr),
        .hart_mask            (hart_mask),
        .step_mode            (step_mode),
        .step                 (step),
        .halt                 (halt),
        .cycle_limit          (cycle_limit),
        .core_reset           (core_reset),
        .core_initial_address (core_initial_address),
        .core_tr              (core_tr),
        .busy                 (busy),
        .done                 (done),
        .cycle_count          (cycle_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulses start for one edge, then scrambles the launch inputs to prove they were latched.
    task automatic launch(input logic [ADDR_W-1:0] addr, input logic [NUM_HARTS-1:0] mask,
                          input logic mode);
        start     = 1'b1;
        boot_addr = addr;
        hart_mask = mask;
        step_mode = mode;
        tick();
        start     = 1'b0;
        boot_addr = 32'hDEAD_BEEF;
        hart_mask = 2'b00;
        step_mode = ~mode;
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; boot_addr = '0; hart_mask = '0;
        step_mode = 1'b0; step = 1'b0; halt = 1'b0; cycle_limit = '0;
        tick(); tick();
        checks++; if (core_reset !== 2'b11) begin failures++; $display("FAIL reset_core_reset got=%b exp=11", core_reset); end
        checks++; if (core_initial_address !== 32'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", core_initial_address); end
        checks++; if (core_tr !== 2'b00) begin failures++; $display("FAIL reset_core_tr got=%b exp=00", core_tr); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL reset_busy_done got=%b%b exp=00", busy, done); end
        checks++; if (cycle_count !== 32'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", cycle_count); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_boot_free_run();
        cycle_limit = 32'd0;
        launch(32'h100, 2'b11, 1'b0);  // edge k
        checks++; if (core_reset !== 2'b11 || busy !== 1'b1) begin failures++; $display("FAIL boot_k got=%b busy=%b exp=11 busy=1", core_reset, busy); end
        tick();                        // edge k+1
        checks++; if (core_reset !== 2'b11 || core_tr !== 2'b00) begin failures++; $display("FAIL boot_k1 got rst=%b tr=%b exp rst=11 tr=00", core_reset, core_tr); end
        tick();                        // edge k+2
        checks++; if (core_reset !== 2'b00 || core_tr !== 2'b11) begin failures++; $display("FAIL boot_k2 got rst=%b tr=%b exp rst=00 tr=11", core_reset, core_tr); end
        checks++; if (core_initial_address !== 32'h100) begin failures++; $display("FAIL boot_addr got=%h exp=100", core_initial_address); end
        checks++; if (cycle_count !== 32'd0) begin failures++; $display("FAIL boot_count0 got=%0d exp=0", cycle_count); end
        tick();
        checks++; if (cycle_count !== 32'd1) begin failures++; $display("FAIL boot_count1 got=%0d exp=1", cycle_count); end
        halt = 1'b1;
        tick();
        halt = 1'b0;
        checks++; if (done !== 1'b1 || core_tr !== 2'b00 || cycle_count !== 32'd2) begin failures++; $display("FAIL halt_free got done=%b tr=%b cnt=%0d exp done=1 tr=00 cnt=2", done, core_tr, cycle_count); end
        tick(); tick();
        checks++; if (cycle_count !== 32'd2 || core_reset !== 2'b00) begin failures++; $display("FAIL done_frozen got cnt=%0d rst=%b exp cnt=2 rst=00", cycle_count, core_reset); end
    endtask

    task automatic test_cycle_limit();
        int  trc;
        bit  seen_done;
        trc = 0; seen_done = 1'b0;
        cycle_limit = 32'd5;
        launch(32'h100, 2'b11, 1'b0);
        for (int i = 0; i < 40 && !seen_done; i++) begin
            tick();
            if (core_tr != 2'b00) trc++;
            if (done) seen_done = 1'b1;
        end
        checks++; if (seen_done !== 1'b1) begin failures++; $display("FAIL limit_timeout got done=%b exp=1", done); end
        checks++; if (trc != 5) begin failures++; $display("FAIL limit_grants got=%0d exp=5", trc); end
        checks++; if (cycle_count !== 32'd5 || core_tr !== 2'b00 || busy !== 1'b0) begin failures++; $display("FAIL limit_end got cnt=%0d tr=%b busy=%b exp cnt=5 tr=00 busy=0", cycle_count, core_tr, busy); end
        tick(); tick();
        checks++; if (cycle_count !== 32'd5 || core_tr !== 2'b00) begin failures++; $display("FAIL limit_hold got cnt=%0d tr=%b exp cnt=5 tr=00", cycle_count, core_tr); end
    endtask

    task automatic test_step_mode();
        int pulses;
        pulses = 0;
        cycle_limit = 32'd0;
        launch(32'h100, 2'b11, 1'b1);
        tick(); tick();
        checks++; if (core_reset !== 2'b00 || core_tr !== 2'b00) begin failures++; $display("FAIL step_entry got rst=%b tr=%b exp rst=00 tr=00", core_reset, core_tr); end
        for (int p = 0; p < 3; p++) begin
            step = 1'b1;
            tick();
            step = 1'b0;
            if (core_tr == 2'b11) pulses++;
            tick();
            if (core_tr != 2'b00) pulses += 10;
            tick();
            if (core_tr != 2'b00) pulses += 10;
        end
        checks++; if (pulses != 3) begin failures++; $display("FAIL step_pulses got=%0d exp=3", pulses); end
        checks++; if (cycle_count !== 32'd3 || busy !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL step_state got cnt=%0d busy=%b done=%b exp cnt=3 busy=1 done=0", cycle_count, busy, done); end
        step = 1'b1;
        tick();
        tick();
        checks++; if (core_tr !== 2'b11 || cycle_count !== 32'd4) begin failures++; $display("FAIL step_held got tr=%b cnt=%0d exp tr=11 cnt=4", core_tr, cycle_count); end
        halt = 1'b1;
        tick();
        halt = 1'b0; step = 1'b0;
        checks++; if (done !== 1'b1 || core_tr !== 2'b00 || cycle_count !== 32'd5) begin failures++; $display("FAIL halt_over_step got done=%b tr=%b cnt=%0d exp done=1 tr=00 cnt=5", done, core_tr, cycle_count); end
    endtask

    task automatic test_halt_limit();
        bit tr1_seen;
        tr1_seen = 1'b0;
        cycle_limit = 32'd3;
        launch(32'h100, 2'b01, 1'b0);
        tick(); if (core_tr[1]) tr1_seen = 1'b1;
        tick(); if (core_tr[1]) tr1_seen = 1'b1;
        checks++; if (core_reset !== 2'b10 || core_tr !== 2'b01) begin failures++; $display("FAIL mask01_run got rst=%b tr=%b exp rst=10 tr=01", core_reset, core_tr); end
        tick(); if (core_tr[1]) tr1_seen = 1'b1;
        tick(); if (core_tr[1]) tr1_seen = 1'b1;
        checks++; if (cycle_count !== 32'd2 || done !== 1'b0) begin failures++; $display("FAIL pre_hit got cnt=%0d done=%b exp cnt=2 done=0", cycle_count, done); end
        halt = 1'b1;
        tick(); if (core_tr[1]) tr1_seen = 1'b1;
        halt = 1'b0;
        checks++; if (done !== 1'b1 || core_tr !== 2'b00 || cycle_count !== 32'd3) begin failures++; $display("FAIL halt_limit got done=%b tr=%b cnt=%0d exp done=1 tr=00 cnt=3", done, core_tr, cycle_count); end
        tick(); if (core_tr[1]) tr1_seen = 1'b1;
        checks++; if (cycle_count !== 32'd3 || core_reset !== 2'b10) begin failures++; $display("FAIL halt_limit_hold got cnt=%0d rst=%b exp cnt=3 rst=10", cycle_count, core_reset); end
        checks++; if (tr1_seen !== 1'b0) begin failures++; $display("FAIL mask01_tr1 got=%b exp=0", tr1_seen); end
    endtask

    task automatic test_ignored_and_reset();
        cycle_limit = 32'd0;
        launch(32'h100, 2'b11, 1'b0);
        start = 1'b1; hart_mask = 2'b01; boot_addr = 32'h300;
        tick();
        start = 1'b0;
        checks++; if (core_reset !== 2'b11 || busy !== 1'b1 || core_initial_address !== 32'h100) begin failures++; $display("FAIL start_in_hold got rst=%b busy=%b addr=%h exp rst=11 busy=1 addr=100", core_reset, busy, core_initial_address); end
        tick();
        checks++; if (core_reset !== 2'b00 || core_tr !== 2'b11) begin failures++; $display("FAIL hold_no_relatch got rst=%b tr=%b exp rst=00 tr=11", core_reset, core_tr); end
        start = 1'b1; hart_mask = 2'b11;
        tick();
        start = 1'b0;
        checks++; if (core_reset !== 2'b00 || core_tr !== 2'b11 || busy !== 1'b1) begin failures++; $display("FAIL start_in_run got rst=%b tr=%b busy=%b exp rst=00 tr=11 busy=1", core_reset, core_tr, busy); end
        #3 reset = 1'b0;
        #1;
        checks++; if (core_reset !== 2'b11 || core_tr !== 2'b00 || core_initial_address !== 32'h0) begin failures++; $display("FAIL midrun_reset got rst=%b tr=%b addr=%h exp rst=11 tr=00 addr=0", core_reset, core_tr, core_initial_address); end
        checks++; if (busy !== 1'b0 || done !== 1'b0 || cycle_count !== 32'd0) begin failures++; $display("FAIL midrun_reset_flags got busy=%b done=%b cnt=%0d exp 0 0 0", busy, done, cycle_count); end
        tick();
        reset = 1'b1;
        tick();
        start = 1'b1; hart_mask = 2'b00; boot_addr = 32'h400;
        tick();
        start = 1'b0;
        tick();
        checks++; if (busy !== 1'b0 || core_reset !== 2'b11 || core_initial_address !== 32'h0) begin failures++; $display("FAIL start_mask0 got busy=%b rst=%b addr=%h exp busy=0 rst=11 addr=0", busy, core_reset, core_initial_address); end
    endtask

    task automatic test_restart();
        bit seen_done;
        seen_done = 1'b0;
        cycle_limit = 32'd2;
        launch(32'h100, 2'b11, 1'b0);
        for (int i = 0; i < 20 && !seen_done; i++) begin
            tick();
            if (done) seen_done = 1'b1;
        end
        checks++; if (seen_done !== 1'b1 || cycle_count !== 32'd2) begin failures++; $display("FAIL restart_prep got done=%b cnt=%0d exp done=1 cnt=2", done, cycle_count); end
        cycle_limit = 32'd0;
        launch(32'h200, 2'b11, 1'b0);
        checks++; if (done !== 1'b0 || cycle_count !== 32'd0 || busy !== 1'b1) begin failures++; $display("FAIL restart_clear got done=%b cnt=%0d busy=%b exp 0 0 1", done, cycle_count, busy); end
        checks++; if (core_reset !== 2'b11 || core_tr !== 2'b00 || core_initial_address !== 32'h200) begin failures++; $display("FAIL restart_hold got rst=%b tr=%b addr=%h exp rst=11 tr=00 addr=200", core_reset, core_tr, core_initial_address); end
        tick();
        checks++; if (core_reset !== 2'b11) begin failures++; $display("FAIL restart_hold2 got=%b exp=11", core_reset); end
        tick();
        checks++; if (core_reset !== 2'b00 || core_tr !== 2'b11) begin failures++; $display("FAIL restart_run got rst=%b tr=%b exp rst=00 tr=11", core_reset, core_tr); end
        tick();
        checks++; if (cycle_count !== 32'd1) begin failures++; $display("FAIL restart_count got=%0d exp=1", cycle_count); end
    endtask

    initial begin
        test_reset();
        test_boot_free_run();
        test_cycle_limit();
        test_step_mode();
        test_halt_limit();
        test_ignored_and_reset();
        test_restart();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
